// File: rtl/pre_if_stage_pkg.sv
// Shared widths, default addresses and state type for the pre-IF stage.
package pre_if_stage_pkg;

  localparam int BR_BUS_WD       = 34;
  localparam int PS_TO_FS_BUS_WD = 64;

  localparam logic [31:0] RESET_PC_DEF  = 32'hbfc00000;
  localparam logic [31:0] EX_VECTOR_DEF = 32'hbfc00380;

  typedef enum logic [1:0] {
    PS_IDLE      = 2'd0,
    PS_WAIT_ADDR = 2'd1,
    PS_WAIT_DATA = 2'd2,
    PS_HOLD      = 2'd3
  } ps_state_e;

  function automatic logic pc_misaligned(input logic [31:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pre_if_stage_redirect_buf.sv
// Redirect priority mux (ws_ex > eret > br_taken) plus a one-entry buffer
// holding a redirect that could not be applied to ps_pc immediately.
module pre_if_stage_redirect_buf
  import pre_if_stage_pkg::*;
#(
  parameter logic [31:0] EX_VECTOR = EX_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ws_ex,
  input  logic        eret,
  input  logic [31:0] cp0_epc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        latch,
  input  logic        clear,
  output logic        redir_now,
  output logic [31:0] now_target,
  output logic        pend,
  output logic [31:0] pend_target
);

  logic        rd_valid;
  logic [31:0] rd_target;

  // A redirect arriving this cycle is newer than a buffered one, so it wins.
  always_comb begin
    redir_now   = ws_ex | eret | br_taken;
    now_target  = ws_ex ? EX_VECTOR : (eret ? cp0_epc : br_target);
    pend        = redir_now | rd_valid;
    pend_target = redir_now ? now_target : rd_target;
  end

  // Buffered redirect; a latch request overrides a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid  <= 1'b0;
      rd_target <= 32'h0;
    end else if (latch && redir_now) begin
      rd_valid  <= 1'b1;
      rd_target <= now_target;
    end else if (clear) begin
      rd_valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/pre_if_stage.sv
// Pre-IF stage: owns the fetch PC, issues one outstanding SRAM fetch at a
// time, holds the returned instruction until IF accepts it.
//
// state        | meaning
// PS_IDLE      | no fetch in flight; apply pending redirect, issue when !br_stall
// PS_WAIT_ADDR | req high, waiting for addr_ok
// PS_WAIT_DATA | accepted, waiting for data_ok (cancel drops it)
// PS_HOLD      | {inst_buf, ps_pc} presented to IF until fs_allowin
module pre_if_stage
  import pre_if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] EX_VECTOR = EX_VECTOR_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fs_allowin,
  input  logic [BR_BUS_WD-1:0]       br_bus,
  input  logic                       ws_ex,
  input  logic                       eret,
  input  logic [31:0]                cp0_epc,
  output logic                       ps_to_fs_valid,
  output logic [PS_TO_FS_BUS_WD-1:0] ps_to_fs_bus,
  output logic                       inst_sram_req,
  output logic                       inst_sram_wr,
  output logic [1:0]                 inst_sram_size,
  output logic [3:0]                 inst_sram_wstrb,
  output logic [31:0]                inst_sram_addr,
  output logic [31:0]                inst_sram_wdata,
  input  logic                       inst_sram_addr_ok,
  input  logic                       inst_sram_data_ok,
  input  logic [31:0]                inst_sram_rdata
);

  ps_state_e   state, next_state;
  logic [31:0] ps_pc, pc_next;
  logic [31:0] inst_buf, inst_next;
  logic        cancel, cancel_next;
  logic        rd_latch, rd_clear;
  logic        redir_now, pend;
  logic [31:0] now_target, pend_target;
  logic [31:0] idle_pc, hold_pc;

  logic        br_stall, br_taken;
  logic [31:0] br_target;

  assign br_stall  = br_bus[33];
  assign br_taken  = br_bus[32];
  assign br_target = br_bus[31:0];

  pre_if_stage_redirect_buf #(.EX_VECTOR(EX_VECTOR)) u_redirect_buf (
    .clk         (clk),
    .reset       (reset),
    .ws_ex       (ws_ex),
    .eret        (eret),
    .cp0_epc     (cp0_epc),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .latch       (rd_latch),
    .clear       (rd_clear),
    .redir_now   (redir_now),
    .now_target  (now_target),
    .pend        (pend),
    .pend_target (pend_target)
  );

  // Next-state, PC, buffer and cancel decisions.
  always_comb begin
    next_state  = state;
    pc_next     = ps_pc;
    inst_next   = inst_buf;
    cancel_next = cancel;
    rd_latch    = 1'b0;
    rd_clear    = 1'b0;
    idle_pc     = pend ? pend_target : ps_pc;
    hold_pc     = pend ? pend_target : ps_pc + 32'd4;
    case (state)
      PS_IDLE: begin
        rd_clear = 1'b1;
        pc_next  = idle_pc;
        // A misaligned PC never reaches the SRAM; IF raises ADEL from the pc.
        if (pc_misaligned(idle_pc)) begin
          next_state = PS_HOLD;
          inst_next  = 32'h0;
        end else if (!br_stall) begin
          next_state = PS_WAIT_ADDR;
        end
      end
      PS_WAIT_ADDR: begin
        if (inst_sram_addr_ok) begin
          next_state = PS_WAIT_DATA;
          if (redir_now) begin
            cancel_next = 1'b1;
            rd_latch    = 1'b1;
          end
        end else if (redir_now) begin
          pc_next = now_target;
          if (pc_misaligned(now_target)) next_state = PS_IDLE;
        end
      end
      PS_WAIT_DATA: begin
        rd_latch = redir_now;
        if (inst_sram_data_ok) begin
          if (cancel || redir_now) begin
            cancel_next = 1'b0;
            next_state  = PS_IDLE;
          end else begin
            inst_next  = inst_sram_rdata;
            next_state = PS_HOLD;
          end
        end else if (redir_now) begin
          cancel_next = 1'b1;
        end
      end
      PS_HOLD: begin
        if (ws_ex || eret) begin
          pc_next    = now_target;
          rd_clear   = 1'b1;
          next_state = PS_IDLE;
        end else if (fs_allowin) begin
          // A branch arriving with allowin is consumed right here.
          pc_next    = hold_pc;
          rd_clear   = 1'b1;
          next_state = (!br_stall && !pc_misaligned(hold_pc)) ? PS_WAIT_ADDR : PS_IDLE;
        end else if (br_taken) begin
          rd_latch = 1'b1;
        end
      end
      default: next_state = PS_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= PS_IDLE;
      ps_pc    <= RESET_PC;
      inst_buf <= 32'h0;
      cancel   <= 1'b0;
    end else begin
      state    <= next_state;
      ps_pc    <= pc_next;
      inst_buf <= inst_next;
      cancel   <= cancel_next;
    end
  end

  assign ps_to_fs_valid  = (state == PS_HOLD);
  assign ps_to_fs_bus    = {inst_buf, ps_pc};
  assign inst_sram_req   = (state == PS_WAIT_ADDR);
  assign inst_sram_addr  = {ps_pc[31:2], 2'b00};
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'd2;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_wdata = 32'h0;

endmodule

// File: tb/tb_pre_if_stage.sv
// Bench for pre_if_stage: directed sequences, a redirect vector table and a
// randomized run checked against a fetch-order model.
module tb_pre_if_stage;
  import pre_if_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        fs_allowin;
  logic [33:0] br_bus;
  logic        ws_ex, eret;
  logic [31:0] cp0_epc;
  logic        ps_to_fs_valid;
  logic [63:0] ps_to_fs_bus;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok = 1'b0;
  logic        inst_sram_data_ok = 1'b0;
  logic [31:0] inst_sram_rdata   = 32'h0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pre_if_stage dut (
    .clk               (clk),
    .reset             (reset),
    .fs_allowin        (fs_allowin),
    .br_bus            (br_bus),
    .ws_ex             (ws_ex),
    .eret              (eret),
    .cp0_epc           (cp0_epc),
    .ps_to_fs_valid    (ps_to_fs_valid),
    .ps_to_fs_bus      (ps_to_fs_bus),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_wstrb   (inst_sram_wstrb),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'hbfc00000) return 32'h24080001;
    return {a[15:0], a[31:16]} ^ 32'h3c015a5a;
  endfunction

  // Entry IF should see for a given pc: misaligned pcs carry a zero instruction.
  function automatic logic [63:0] entry(input logic [31:0] pc);
    return {(pc[1:0] != 2'b00) ? 32'h0 : mem(pc), pc};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, output int nreq);
    int n = 0;
    nreq = 0;
    while (!ps_to_fs_valid && n < 60) begin
      if (inst_sram_req) nreq++;
      step();
      n++;
    end
    if (!ps_to_fs_valid) begin
      checks++;
      errors++;
      $display("FAIL %s: valid still %b after %0d cycles, expected 1", name, ps_to_fs_valid, n);
    end
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!inst_sram_req && n < 60) begin
      step();
      n++;
    end
    if (!inst_sram_req) begin
      checks++;
      errors++;
      $display("FAIL %s: req still %b after %0d cycles, expected 1", name, inst_sram_req, n);
    end
  endtask

  // SRAM responder: one outstanding access, data_ok after a programmable latency.
  int          aok_mode = 0;
  int          dlat_min = 0;
  int          dlat_max = 0;
  int          acc_cnt  = 0;
  int          lat      = 0;
  logic        outst    = 1'b0;
  logic        req_s    = 1'b0;
  logic [31:0] addr_s   = 32'h0;
  logic [31:0] pend_addr = 32'h0;
  logic        rst_seen = 1'b1;
  logic        redir_seen = 1'b0;

  always @(posedge clk) begin
    rst_seen   <= reset;
    redir_seen <= ws_ex | eret | br_bus[32];
  end

  always @(negedge clk) begin
    if (inst_sram_data_ok) outst = 1'b0;
    if (req_s && inst_sram_addr_ok) begin
      outst     = 1'b1;
      pend_addr = addr_s;
      lat       = $urandom_range(dlat_max, dlat_min);
      acc_cnt++;
    end else if (req_s && !rst_seen) begin
      chk("req_held", {63'b0, inst_sram_req}, 64'd1);
      if (!redir_seen) chk("addr_held", {32'b0, inst_sram_addr}, {32'b0, addr_s});
    end
    req_s  = inst_sram_req;
    addr_s = inst_sram_addr;
    inst_sram_data_ok = 1'b0;
    if (outst) begin
      if (lat == 0) begin
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata   = mem(pend_addr);
      end else begin
        lat--;
      end
    end
    inst_sram_addr_ok = !outst && (aok_mode == 0 ? 1'b1 :
                                   aok_mode == 1 ? 1'b0 : 1'($urandom_range(1, 0)));
  end

  typedef struct {
    logic        ws;
    logic        er;
    logic        br;
    logic [31:0] epc;
    logic [31:0] tgt;
    logic        alw;
    logic        extra;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int          nreq, bad, acc0, hs;
    logic        found, pend, br_t, stall;
    logic [31:0] prev, exp_pc, ptgt, tgt;
    logic [63:0] saved;

    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'hbfc00380};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 32'h0,        32'hbfc00010, 1'b1, 1'b0, 32'hbfc00010};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 32'h0,        32'hbfc00100, 1'b1, 1'b0, 32'hbfc00100};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 32'hbfc00200, 32'hbfc00300, 1'b0, 1'b0, 32'hbfc00380};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 32'hbfc00200, 32'hbfc00300, 1'b0, 1'b0, 32'hbfc00200};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 32'hbfc00002, 32'h0,        1'b0, 1'b0, 32'hbfc00002};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 32'h0,        32'hbfc00040, 1'b1, 1'b0, 32'hbfc00040};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 32'hbfc00400, 32'h0,        1'b0, 1'b0, 32'hbfc00400};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 32'h0,        32'hbfc00500, 1'b0, 1'b1, 32'hbfc00500};

    reset = 1'b1; fs_allowin = 1'b1; br_bus = '0; ws_ex = 1'b0; eret = 1'b0; cp0_epc = 32'h0;
    repeat (3) step();
    chk("rst_valid", {63'b0, ps_to_fs_valid}, 64'd0);
    chk("rst_req",   {63'b0, inst_sram_req},  64'd0);
    chk("tie_wr",    {63'b0, inst_sram_wr},   64'd0);
    chk("tie_size",  {62'b0, inst_sram_size}, 64'd2);
    chk("tie_wstrb", {60'b0, inst_sram_wstrb}, 64'd0);
    chk("tie_wdata", {32'b0, inst_sram_wdata}, 64'd0);
    reset = 1'b0;

    // First fetch after reset, then addr_ok withheld for five cycles.
    wait_req("first_req_wait");
    chk("first_req_addr", {32'b0, inst_sram_addr}, 64'hbfc00000);
    wait_valid("first_entry_wait", nreq);
    chk("first_entry", ps_to_fs_bus, {32'h24080001, 32'hbfc00000});
    aok_mode = 1;
    wait_req("second_req_wait");
    acc0 = acc_cnt;
    for (int k = 0; k < 5; k++) begin
      chk("stall_req",  {63'b0, inst_sram_req},  64'd1);
      chk("stall_addr", {32'b0, inst_sram_addr}, 64'hbfc00004);
      step();
    end
    aok_mode = 0;
    wait_valid("second_entry_wait", nreq);
    chk("one_txn", 64'(acc_cnt - acc0), 64'd1);
    chk("second_entry", ps_to_fs_bus, entry(32'hbfc00004));

    // Exception while the fetch of 0xbfc00008 is outstanding.
    dlat_min = 3; dlat_max = 3;
    wait_req("c_req_wait");
    bad = 0;
    while (inst_sram_req && bad < 20) begin step(); bad++; end
    ws_ex = 1'b1;
    step();
    ws_ex = 1'b0;
    bad = 0; found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (ps_to_fs_valid) bad++;
      if (inst_sram_req) found = 1'b1;
      else step();
    end
    chk("ex_entry_dropped", 64'(bad), 64'd0);
    chk("ex_req_seen", {63'b0, found}, 64'd1);
    chk("ex_req_addr", {32'b0, inst_sram_addr}, 64'hbfc00380);

    // IF back-pressure in HOLD.
    dlat_min = 0; dlat_max = 0;
    fs_allowin = 1'b0;
    wait_valid("d_valid_wait", nreq);
    chk("d_entry", ps_to_fs_bus, entry(32'hbfc00380));
    saved = ps_to_fs_bus;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("d_hold_valid", {63'b0, ps_to_fs_valid}, 64'd1);
      chk("d_hold_bus",   ps_to_fs_bus, saved);
      chk("d_hold_noreq", {63'b0, inst_sram_req}, 64'd0);
    end
    fs_allowin = 1'b1;
    step();
    fs_allowin = 1'b0;
    chk("d_valid_drop", {63'b0, ps_to_fs_valid}, 64'd0);
    chk("d_fast_req",   {63'b0, inst_sram_req},  64'd1);
    chk("d_fast_addr",  {32'b0, inst_sram_addr}, 64'hbfc00384);
    wait_valid("tbl_start_wait", nreq);

    // Redirect table, each vector applied while an entry is held.
    aok_mode = 2; dlat_max = 2;
    prev = 32'h0;
    for (int i = 0; i < 9; i++) begin
      ws_ex = tbl[i].ws; eret = tbl[i].er; cp0_epc = tbl[i].epc;
      br_bus = {1'b0, tbl[i].br, tbl[i].tgt}; fs_allowin = tbl[i].alw;
      chk("tbl_cur_valid", {63'b0, ps_to_fs_valid}, 64'd1);
      if (i > 0) chk("tbl_cur_pc", {32'b0, ps_to_fs_bus[31:0]}, {32'b0, prev});
      step();
      ws_ex = 1'b0; eret = 1'b0; br_bus = '0; fs_allowin = 1'b0;
      if (tbl[i].extra) begin
        fs_allowin = 1'b1;
        chk("tbl_delay_slot_valid", {63'b0, ps_to_fs_valid}, 64'd1);
        chk("tbl_delay_slot_pc", {32'b0, ps_to_fs_bus[31:0]}, {32'b0, prev});
        step();
        fs_allowin = 1'b0;
      end
      wait_valid("tbl_next_wait", nreq);
      chk("tbl_next_entry", ps_to_fs_bus, entry(tbl[i].exp));
      if (tbl[i].exp[1:0] != 2'b00) chk("tbl_misaligned_noreq", 64'(nreq), 64'd0);
      prev = tbl[i].exp;
    end

    // Randomized run with taken branches in HOLD and a reset mid-stream.
    reset = 1'b1; step(); step(); reset = 1'b0;
    exp_pc = 32'hbfc00000; pend = 1'b0; ptgt = 32'h0; hs = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      if (cyc == 1500) reset = 1'b1;
      if (cyc == 1502) reset = 1'b0;
      fs_allowin = ($urandom_range(3, 0) != 0);
      stall = ($urandom_range(3, 0) == 0);
      br_t  = !reset && ps_to_fs_valid && ($urandom_range(5, 0) == 0);
      tgt   = {20'hbfc00, 10'($urandom_range(1023, 0)), 2'b00};
      br_bus = {stall, br_t, tgt};
      if (reset) begin
        exp_pc = 32'hbfc00000;
        pend   = 1'b0;
      end else if (ps_to_fs_valid) begin
        if (br_t) begin
          pend = 1'b1;
          ptgt = tgt;
        end
        if (fs_allowin) begin
          chk("rand_entry", ps_to_fs_bus, entry(exp_pc));
          hs++;
          exp_pc = pend ? ptgt : exp_pc + 32'd4;
          pend   = 1'b0;
        end
      end
    end
    br_bus = '0;
    chk("rand_progress", {63'b0, hs >= 100}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
